morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder_if.sv | 28 ++
 rtl/morse_decoder.sv | 136 +++++++++++++
 tb/tb_morse_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Morse decoder bus: serial line in, decoded letter/status out.
// The transmitter side is master; the decoder side is slave.
interface morse_decoder_if;
    logic        DotDashIn;
    logic [2:0]  Letter;
    logic        LetterValid;
    logic        Error;
    logic [11:0] Pattern;
    logic        Busy;

    modport master (
        output DotDashIn,
        input  Letter,
        input  LetterValid,
        input  Error,
        input  Pattern,
        input  Busy
    );

    modport slave (
        input  DotDashIn,
        output Letter,
        output LetterValid,
        output Error,
        output Pattern,
        output Busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder: samples a 12-unit serial frame at mid-unit and
// matches it against an 8-letter table (A..H).
module morse_decoder #(
    parameter int TICK_DIV = 250
) (
    input  logic ClockIn,
    input  logic Reset,
    morse_decoder_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [PW-1:0] FULL = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CHECK
    } state_t;

    state_t        state, stateNxt;
    logic          syncA, syncS, syncSd;
    logic [PW-1:0] phase, phaseNxt;
    logic [3:0]    bitCnt, bitCntNxt;
    logic [11:0]   capReg, capNxt;
    logic [11:0]   patReg, patNxt;
    logic [2:0]    letReg, letNxt;
    logic          lvReg, lvNxt;
    logic          errReg, errNxt;
    logic          hit;
    logic [2:0]    code;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            syncA  <= 1'b0;
            syncS  <= 1'b0;
            syncSd <= 1'b0;
        end else begin
            syncA  <= bus.DotDashIn;
            syncS  <= syncA;
            syncSd <= syncS;
        end
    end

    // Letter table lookup on the captured frame
    always_comb begin
        hit  = 1'b1;
        code = 3'd0;
        case (capReg)
            12'hB80: code = 3'd0;
            12'hEA8: code = 3'd1;
            12'hEBA: code = 3'd2;
            12'hEA0: code = 3'd3;
            12'h800: code = 3'd4;
            12'hAE8: code = 3'd5;
            12'hEE8: code = 3'd6;
            12'hAA0: code = 3'd7;
            default: hit  = 1'b0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        stateNxt  = state;
        phaseNxt  = phase;
        bitCntNxt = bitCnt;
        capNxt    = capReg;
        patNxt    = patReg;
        letNxt    = letReg;
        lvNxt     = 1'b0;
        errNxt    = 1'b0;
        case (state)
            IDLE: begin
                if (syncS && !syncSd) begin
                    stateNxt  = CAPTURE;
                    phaseNxt  = HALF;
                    bitCntNxt = 4'd0;
                end
            end
            CAPTURE: begin
                if (phase == '0) begin
                    capNxt    = {capReg[10:0], syncS};
                    bitCntNxt = bitCnt + 4'd1;
                    phaseNxt  = FULL;
                    if (bitCnt == 4'd0 && !syncS) begin
                        stateNxt = IDLE;
                    end else if (bitCnt == 4'd11) begin
                        stateNxt = CHECK;
                    end
                end else begin
                    phaseNxt = phase - PW'(1);
                end
            end
            CHECK: begin
                patNxt   = capReg;
                stateNxt = IDLE;
                if (hit) begin
                    lvNxt  = 1'b1;
                    letNxt = code;
                end else begin
                    errNxt = 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            phase  <= '0;
            bitCnt <= 4'd0;
            capReg <= 12'h000;
            patReg <= 12'h000;
            letReg <= 3'd0;
            lvReg  <= 1'b0;
            errReg <= 1'b0;
        end else begin
            state  <= stateNxt;
            phase  <= phaseNxt;
            bitCnt <= bitCntNxt;
            capReg <= capNxt;
            patReg <= patNxt;
            letReg <= letNxt;
            lvReg  <= lvNxt;
            errReg <= errNxt;
        end
    end

    assign bus.Letter      = letReg;
    assign bus.LetterValid = lvReg;
    assign bus.Error       = errReg;
    assign bus.Pattern     = patReg;
    assign bus.Busy        = (state != IDLE);
endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at 250 cycles per unit.
// Pulses are recorded by a monitor and checked after each step.
module tb_morse_decoder;
    localparam int TD = 250;

    logic clk = 1'b0;
    logic rst = 1'b1;
    morse_decoder_if bus ();

    morse_decoder #(.TICK_DIV(TD)) dut (
        .ClockIn(clk),
        .Reset  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;
    int lvCnt = 0;
    int erCnt = 0;
    int bothCnt = 0;
    int busyRise = 0;
    int busyFall = 0;
    int startCyc = 0;
    logic prevBusy = 1'b0;
    int pulseCyc[$];
    int pulseLet[$];

    // Cycle counter on the active edge
    always @(posedge clk) cyc++;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.LetterValid === 1'b1) begin
            lvCnt++;
            pulseCyc.push_back(cyc);
            pulseLet.push_back(int'(bus.Letter));
        end
        if (bus.Error === 1'b1) erCnt++;
        if (bus.LetterValid === 1'b1 && bus.Error === 1'b1) bothCnt++;
        if (bus.Busy === 1'b1 && prevBusy === 1'b0) busyRise = cyc;
        if (bus.Busy === 1'b0 && prevBusy === 1'b1) busyFall = cyc;
        prevBusy = bus.Busy;
    end

    task automatic check(input string tag, input int obs, input int exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.DotDashIn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBits(input logic [11:0] p, input int nBits);
        for (int i = 11; i > 11 - nBits; i--) begin
            if (i == 11) startCyc = cyc;
            bus.DotDashIn = p[i];
            repeat (TD) @(negedge clk);
        end
    endtask

    int lv0, er0, q0;

    initial begin
        bus.DotDashIn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_letter", int'(bus.Letter), 0);
        check("rst_lv", int'(bus.LetterValid), 0);
        check("rst_err", int'(bus.Error), 0);
        check("rst_pattern", int'(bus.Pattern), 'h000);
        check("rst_busy", int'(bus.Busy), 0);
        rst = 1'b0;
        idle(10);

        // Letter A
        lv0 = lvCnt; er0 = erCnt; q0 = pulseLet.size();
        sendBits(12'hB80, 12);
        idle(20);
        check("A_lv", lvCnt - lv0, 1);
        check("A_err", erCnt - er0, 0);
        check("A_letter", pulseLet[q0], 0);
        check("A_pattern", int'(bus.Pattern), 'hB80);

        // Letter H, with Busy timing
        lv0 = lvCnt; q0 = pulseLet.size();
        sendBits(12'hAA0, 12);
        idle(20);
        check("H_lv", lvCnt - lv0, 1);
        check("H_letter", pulseLet[q0], 7);
        check("H_busy_rise", busyRise - startCyc, 3);
        check("H_busy_fall", busyFall, pulseCyc[q0]);
        check("H_pattern", int'(bus.Pattern), 'hAA0);

        // Invalid frame
        lv0 = lvCnt; er0 = erCnt;
        sendBits(12'hC00, 12);
        idle(20);
        check("C00_err", erCnt - er0, 1);
        check("C00_lv", lvCnt - lv0, 0);
        check("C00_pattern", int'(bus.Pattern), 'hC00);
        check("C00_letter", int'(bus.Letter), 7);

        // Short glitch
        lv0 = lvCnt; er0 = erCnt;
        startCyc = cyc;
        bus.DotDashIn = 1'b1;
        repeat (10) @(negedge clk);
        idle(400);
        check("gl_lv", lvCnt - lv0, 0);
        check("gl_err", erCnt - er0, 0);
        check("gl_busy_fall", busyFall - startCyc, 128);
        check("gl_pattern", int'(bus.Pattern), 'hC00);
        check("gl_busy", int'(bus.Busy), 0);

        // Reset in the middle of a frame
        lv0 = lvCnt; er0 = erCnt;
        sendBits(12'hEBA, 5);
        rst = 1'b1;
        bus.DotDashIn = 1'b0;
        #1;
        check("mr_busy", int'(bus.Busy), 0);
        check("mr_pattern", int'(bus.Pattern), 'h000);
        check("mr_letter", int'(bus.Letter), 0);
        check("mr_lv", int'(bus.LetterValid), 0);
        check("mr_err", int'(bus.Error), 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(3000);
        check("mr_nolv", lvCnt - lv0, 0);
        check("mr_noerr", erCnt - er0, 0);
        q0 = pulseLet.size();
        sendBits(12'hEBA, 12);
        idle(20);
        check("C_lv", lvCnt - lv0, 1);
        check("C_letter", pulseLet[q0], 2);
        check("C_pattern", int'(bus.Pattern), 'hEBA);

        // Three back-to-back G frames
        lv0 = lvCnt; er0 = erCnt; q0 = pulseLet.size();
        sendBits(12'hEE8, 12);
        sendBits(12'hEE8, 12);
        sendBits(12'hEE8, 12);
        idle(20);
        check("G3_lv", lvCnt - lv0, 3);
        check("G3_err", erCnt - er0, 0);
        if (pulseLet.size() >= q0 + 3) begin
            check("G3_let0", pulseLet[q0], 6);
            check("G3_let1", pulseLet[q0 + 1], 6);
            check("G3_let2", pulseLet[q0 + 2], 6);
            check("G3_gap01", pulseCyc[q0 + 1] - pulseCyc[q0], 3000);
            check("G3_gap12", pulseCyc[q0 + 2] - pulseCyc[q0 + 1], 3000);
        end else begin
            check("G3_pulses", pulseLet.size() - q0, 3);
        end
        check("G3_pattern", int'(bus.Pattern), 'hEE8);
        check("never_both", bothCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
